multibyte_add_seq: RTL and testbench
====================================

Name: multibyte_add_seq

Overview:
Sequencer that performs wide (8*NBYTES-bit) additions by time-multiplexing one 8-bit adder slice (x + y + cin → sum, cout), one byte per clock, LSB first.
- Chains the carry between bytes through a carry register.
- Start/busy/done handshake; sum and cout registered and held until the next operation completes.
- Sits between the team's 8-bit adder datapath and any client needing 16/24/32-bit sums without widening the adder.

Parameters:
NBYTES, 4, number of byte slices processed per operation (operand width = 8*NBYTES); legal range 2..16.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  8*NBYTES  operand A; captured on accepted start
b  input  8*NBYTES  operand B; captured on accepted start
cin  input  1  carry-in to byte 0; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: sum/cout just updated
sum  output  8*NBYTES  registered result, held between operations
cout  output  1  registered carry-out of the most significant byte

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, work and carry registers and byte index cleared. Effective immediately, regardless of clock.
- States: IDLE, RUN, DONE. Byte index idx is ceil(log2(NBYTES))+1 bits wide.
- IDLE:
  - start=1 at an edge: latch a, b into operand shift registers; carry_reg=cin; idx=0; go to RUN.
  - start=0: stay.
- RUN, each edge:
  - Adder inputs are the low byte of A, the low byte of B, and carry_reg.
  - Slice sum is written into byte idx of the work register; carry_reg takes slice cout.
  - Operand registers shift right by 8; idx increments.
  - When idx=NBYTES-1 is processed: sum takes the complete work register, cout takes the final carry, done=1, go to DONE.
- DONE: lasts one cycle; done=1, busy=0.
  - start=1 is accepted exactly as in IDLE (back-to-back operations allowed); otherwise go to IDLE.
  - done clears on the next edge.
- busy=1 exactly in RUN; busy is a registered output.
- Latency: start accepted at edge E0; bytes processed at edges E1..E(NBYTES); done=1 and sum/cout valid from E(NBYTES) until E(NBYTES+1). Throughput is one operation per NBYTES+1 cycles.
- start while busy=1 is ignored; it has no effect on the operands or the result.
- a, b, cin may change freely after acceptance; only the captured copies are used.
- sum/cout keep the previous result throughout RUN. They change only at completion, never with partial bytes.
- Wrap-around: the result is modulo 2^(8*NBYTES); overflow is reported only via cout. No signed overflow flag.
- Reset mid-operation aborts:
  - no done pulse;
  - sum and cout return to 0;
  - the next start begins a fresh operation.
- No combinational path from inputs to outputs.

Optional Feature:
SUB_EN:
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - When sub=1, every byte of B is inverted before the adder, and the initial carry is forced to 1 (cin ignored). Result is a - b mod 2^(8*NBYTES).
  - cout=1 means no borrow (a ≥ b unsigned).
  - sub=0 behaves exactly as the base block.
- Undefined: port sub does not exist; add-only.

Test Plan:
1. Assert rst asynchronously mid-cycle → busy, done, sum, cout all 0 before the next clock edge; stay 0 with start=0.
2. NBYTES=4, a=0x000000FF, b=0x00000001, cin=0, start pulse → busy high 4 cycles; done pulse 4 edges after acceptance; sum=0x00000100, cout=0.
3. a=0xFFFFFFFF, b=0x00000000, cin=1 → carry ripples through all bytes: sum=0x00000000, cout=1; sum holds old value until the done edge.
4. Start op (a=0x12345678, b=0x11111111); second start with a=b=0xFFFFFFFF two cycles later → ignored. sum=0x23456789, cout=0; only one done pulse.
5. Start asserted during the DONE cycle with a=1, b=2 → accepted; next result sum=3 after 4 more cycles; no idle gap.
6. rst pulse at the second RUN cycle of a=0xFFFFFFFF+1 → no done, sum=0, cout=0. With SUB_EN defined, sub=1, a=5, b=7: sum=0xFFFFFFFE, cout=0; a=7, b=5: sum=2, cout=1.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// Wide adder built from one 8-bit slice, one byte per clock, LSB first.
// Define SUB_EN to add a 'sub' input that turns the operation into a - b.
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [W-1:0]    opa_q;
    logic [W-1:0]    opb_q;
    logic [W-1:0]    work_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            cout_q;
    logic            busy_q;
    logic            done_q;
`ifdef SUB_EN
    logic            sub_q;
`endif

    logic [7:0]      b_byte;
    logic [7:0]      slice_sum;
    logic            slice_cout;
    logic [W-1:0]    work_d;
    logic            carry_init;

    // One 8-bit slice plus the work register with the current byte merged in.
    always_comb begin
        b_byte     = opb_q[7:0];
        carry_init = cin;
`ifdef SUB_EN
        if (sub_q) begin
            b_byte = ~opb_q[7:0];
        end
        if (sub) begin
            carry_init = 1'b1;
        end
`endif
        {slice_cout, slice_sum} = {1'b0, opa_q[7:0]} + {1'b0, b_byte} + {8'd0, carry_q};
        work_d = work_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                work_d[8*i +: 8] = slice_sum;
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= carry_init;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
`ifdef SUB_EN
                        sub_q   <= sub;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    work_q  <= work_d;
                    carry_q <= slice_cout;
                    opa_q   <= opa_q >> 8;
                    opb_q   <= opb_q >> 8;
                    idx_q   <= idx_q + 1'b1;
                    // The result is published only once the top byte is in.
                    if (idx_q == IW'(NBYTES - 1)) begin
                        sum_q   <= work_d;
                        cout_q  <= slice_cout;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_multibyte_add_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  prev_sum  = '0;
    logic          prev_cout = 1'b0;

    multibyte_add_seq #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the whole wide operation done in one line of arithmetic.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Called at the negedge after the accepting edge; returns at the negedge
    // after the completion edge with done checked.
    task automatic track(input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic ec, input logic es, input bit glitch);
        logic [W:0] r;
        r = ref_op(ea, eb, ec, es);
        for (int i = 0; i < NBYTES; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("sum_hold", sum, prev_sum);
            check("cout_hold", cout, prev_cout);
            if (glitch && i == 1) begin
                a = '1;
                b = '1;
                cin = 1'b1;
                start = 1'b1;
            end
            if (glitch && i == 2) start = 1'b0;
            @(negedge clk);
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("sum_result", sum, r[W-1:0]);
        check("cout_result", cout, r[W]);
        prev_sum  = r[W-1:0];
        prev_cout = r[W];
    endtask

    task automatic go(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic ts, input bit glitch);
        @(negedge clk);
        a = ta;
        b = tb_v;
        cin = tc;
        sub = ts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom);
        track(ta, tb_v, tc, ts, glitch);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_stays", busy, 0);

        // Byte carry into the second byte.
        go(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        expect_idle("t2");

        // Carry-in ripples through every byte and out the top.
        go(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        expect_idle("t3");

        // A start while busy must be ignored.
        go(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1);
        expect_idle("t4");

        // Back-to-back: new start during the DONE cycle.
        go(32'hDEAD_BEEF, 32'h0102_0304, 1'b1, 1'b0, 0);
        a = 32'd1;
        b = 32'd2;
        cin = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        track(32'd1, 32'd2, 1'b0, 1'b0, 0);
        expect_idle("t5");

        // Asynchronous reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 32'hFFFF_FFFF;
        b = 32'd1;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        #1 rst = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        for (int i = 0; i < NBYTES + 2; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_sum_zero", sum, 0);
        end

        // Fresh operation after the abort.
        go(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0);
        expect_idle("t6");

`ifdef SUB_EN
        go(32'd5, 32'd7, 1'b0, 1'b1, 0);
        expect_idle("sub_borrow");
        go(32'd7, 32'd5, 1'b0, 1'b1, 0);
        expect_idle("sub_noborrow");
`endif

        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
`ifdef SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (n % 5 == 0) ra = '1;
            go(ra, rb, rc, rs, 0);
            if (n % 3 == 0) expect_idle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
